// File: rtl/sevseg_hex_multi.sv
// sevseg_hex_multi
//   Multi-digit seven-segment controller behind an Avalon-MM slave. Software
//   writes a packed hex value and each nibble is decoded in hardware into
//   one digit. The block also provides decimal-point control, leading-zero
//   blanking, a global enable and a programmable blink timer.
//
// Registers (address):
//   0 CTRL      : bit0 EN, bit1 BLINK_EN, bit2 LZB; read bit31 = blink phase
//   1 HEX       : nibble i drives digit i
//   2 BLINK_DIV : clocks per blink half-period; a write restarts the timer
//   3 DP        : decimal-point lit mask, bit i = digit i
//
// Ports:
//   clk, reset            : single clock domain, async active-high reset
//   address, chipselect,
//   write_n, writedata    : Avalon-MM slave write side
//   readdata              : combinational read data, zero wait states
//   seg_out               : digit i on [7i+6:7i], bit 0 = a ... bit 6 = g
//   dp_out                : decimal point per digit
module sevseg_hex_multi #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter logic [31:0] BLINK_DEFAULT = 32'd25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic [NUM_DIGITS-1:0]   dp_out
);

  localparam int unsigned HW = 4 * NUM_DIGITS;
  localparam int unsigned SW = 7 * NUM_DIGITS;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_HEX  = 2'd1;
  localparam logic [1:0] ADDR_DIV  = 2'd2;
  localparam logic [1:0] ADDR_DP   = 2'd3;

  // Dark level of the pins, which is also their reset level.
  localparam logic [SW-1:0]         SEG_DARK = ACTIVE_LOW ? {SW{1'b1}} : {SW{1'b0}};
  localparam logic [NUM_DIGITS-1:0] DP_DARK  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  // Hex nibble to active-high segment pattern (bit 0 = a ... bit 6 = g).
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [2:0]            ctrl_q,  ctrl_d;
  logic [HW-1:0]         hex_q,   hex_d;
  logic [31:0]           div_q,   div_d;
  logic [NUM_DIGITS-1:0] dp_q,    dp_d;
  logic [31:0]           cnt_q,   cnt_d;
  logic                  phase_q, phase_d;
  logic [SW-1:0]         seg_q,   seg_d;
  logic [NUM_DIGITS-1:0] dpo_q,   dpo_d;

  logic                  wr_en_s;
  logic                  blank_all_s;
  logic                  zero_run_s;
  logic [3:0]            nib_s;
  logic [SW-1:0]         seg_raw_s;
  logic [NUM_DIGITS-1:0] dp_raw_s;
  logic [31:0]           rdata_s;

  assign wr_en_s = chipselect & ~write_n;

  // Register-file writes from the slave port.
  always_comb begin
    ctrl_d = ctrl_q;
    hex_d  = hex_q;
    div_d  = div_q;
    dp_d   = dp_q;
    if (wr_en_s) begin
      case (address)
        ADDR_CTRL: ctrl_d = writedata[2:0];
        ADDR_HEX:  hex_d  = writedata[HW-1:0];
        ADDR_DIV:  div_d  = writedata;
        ADDR_DP:   dp_d   = writedata[NUM_DIGITS-1:0];
        default:   ctrl_d = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Blink timer; a BLINK_DIV write restarts it and takes priority over a
  // terminal count landing on the same edge.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr_en_s && (address == ADDR_DIV)) begin
      cnt_d   = 32'd0;
      phase_d = 1'b0;
    end else if (div_q == 32'd0) begin
      cnt_d   = 32'd0;
      phase_d = 1'b0;
    end else if (cnt_q >= (div_q - 32'd1)) begin
      cnt_d   = 32'd0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 32'd1;
      phase_d = phase_q;
    end
  end

  // Display image: decode, blanking and pin polarity. Digits are walked
  // from the top so zero_run_s says "this nibble and all above are zero".
  always_comb begin
    seg_raw_s   = {SW{1'b0}};
    zero_run_s  = 1'b1;
    nib_s       = 4'h0;
    blank_all_s = ~ctrl_q[0] | (ctrl_q[1] & phase_q);
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib_s      = hex_q[4*i +: 4];
      zero_run_s = zero_run_s & (nib_s == 4'h0);
      if (blank_all_s) begin
        seg_raw_s[7*i +: 7] = 7'h00;
      end else if (ctrl_q[2] && (i > 0) && zero_run_s) begin
        seg_raw_s[7*i +: 7] = 7'h00;
      end else begin
        seg_raw_s[7*i +: 7] = hex_decode(nib_s);
      end
    end
    dp_raw_s = blank_all_s ? {NUM_DIGITS{1'b0}} : dp_q;
    seg_d    = ACTIVE_LOW ? ~seg_raw_s : seg_raw_s;
    dpo_d    = ACTIVE_LOW ? ~dp_raw_s  : dp_raw_s;
  end

  // Read mux; unused upper bits read as zero.
  always_comb begin
    rdata_s = 32'd0;
    case (address)
      ADDR_CTRL: rdata_s = {phase_q, 28'd0, ctrl_q};
      ADDR_HEX:  rdata_s[HW-1:0] = hex_q;
      ADDR_DIV:  rdata_s = div_q;
      ADDR_DP:   rdata_s[NUM_DIGITS-1:0] = dp_q;
      default:   rdata_s = 32'd0;
    endcase
  end

  assign readdata = rdata_s;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= 3'd0;
      hex_q   <= {HW{1'b0}};
      div_q   <= BLINK_DEFAULT;
      dp_q    <= {NUM_DIGITS{1'b0}};
      cnt_q   <= 32'd0;
      phase_q <= 1'b0;
      seg_q   <= SEG_DARK;
      dpo_q   <= DP_DARK;
    end else begin
      ctrl_q  <= ctrl_d;
      hex_q   <= hex_d;
      div_q   <= div_d;
      dp_q    <= dp_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
    end
  end

  assign seg_out = seg_q;
  assign dp_out  = dpo_q;

endmodule

// File: tb/tb_sevseg_hex_multi.sv
// Testbench for sevseg_hex_multi (NUM_DIGITS=4, ACTIVE_LOW=1).
module tb_sevseg_hex_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [27:0] seg_out;
  logic [3:0]  dp_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  ctrl;
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [27:0] seg;
    logic [3:0]  dpo;
  } vec_t;

  typedef struct {
    logic [27:0] seg;
    logic [3:0]  dpo;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  sevseg_hex_multi #(
    .NUM_DIGITS(4),
    .ACTIVE_LOW(1'b1),
    .BLINK_DEFAULT(32'd25000000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .seg_out(seg_out),
    .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus write: captured on the next rising edge, returns #1 after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
    address = 2'd0;
  endtask

  // Pop the oldest expectation and compare it with the current outputs.
  task automatic sb_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_seg"}, {4'd0, seg_out}, {4'd0, e.seg});
      chk({name, "_dp"}, {28'd0, dp_out}, {28'd0, e.dpo});
    end
  endtask

  initial begin
    exp_t e;
    int   ph_now;
    int   ph_prev;
    bit   seen;

    vecs[0] = '{3'd1, 16'h12AF, 4'h0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF};
    vecs[1] = '{3'd5, 16'h0007, 4'h0, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'hF};
    vecs[2] = '{3'd5, 16'h0000, 4'h0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
    vecs[3] = '{3'd1, 16'h0000, 4'h5, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hA};
    vecs[4] = '{3'd0, 16'h0000, 4'h5, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF};
    vecs[5] = '{3'd5, 16'h0300, 4'h0, {7'h7F, 7'h30, 7'h40, 7'h40}, 4'hF};
    vecs[6] = '{3'd1, 16'h89CD, 4'hF, {7'h00, 7'h10, 7'h46, 7'h21}, 4'h0};
    vecs[7] = '{3'd5, 16'h4560, 4'hA, {7'h19, 7'h12, 7'h02, 7'h40}, 4'h5};
    vecs[8] = '{3'd7, 16'h0B0E, 4'h2, {7'h7F, 7'h03, 7'h40, 7'h06}, 4'hD};

    // Reset state.
    #12;
    chk("rst_seg", {4'd0, seg_out}, 32'h0FFF_FFFF);
    chk("rst_dp", {28'd0, dp_out}, 32'h0000_000F);
    rd_chk("rst_div", 2'd2, 32'd25000000);
    rd_chk("rst_ctrl", 2'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table of static display patterns.
    for (int v = 0; v < 9; v++) begin
      wr(2'd0, {29'd0, vecs[v].ctrl});
      wr(2'd1, {16'd0, vecs[v].hex});
      wr(2'd3, {28'd0, vecs[v].dp});
      e.seg = vecs[v].seg;
      e.dpo = vecs[v].dpo;
      sb.push_back(e);
      @(posedge clk);
      #1;
      sb_check($sformatf("vec%0d", v));
    end

    // Readback and write-ignored upper bits.
    wr(2'd3, 32'hFFFF_FFF5);
    rd_chk("rd_dp", 2'd3, 32'h0000_0005);
    wr(2'd1, 32'hABCD_1234);
    rd_chk("rd_hex", 2'd1, 32'h0000_1234);
    wr(2'd0, 32'h7FFF_FFF8);
    rd_chk("rd_ctrl", 2'd0, 32'h0000_0000);

    // Blink with BLINK_DIV=3; the div write edge is n=0.
    wr(2'd3, 32'h0000_000F);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'd3);
    wr(2'd1, 32'h0000_8888);
    for (int n = 3; n <= 20; n++) begin
      ph_prev = ((n - 1) / 3) % 2;
      ph_now  = (n / 3) % 2;
      e.seg = (ph_prev == 1) ? 28'hFFF_FFFF : 28'h000_0000;
      e.dpo = (ph_prev == 1) ? 4'hF : 4'h0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      sb_check($sformatf("blink%0d", n));
      chk($sformatf("phase%0d", n), {31'd0, readdata[31]}, ph_now[31:0]);
    end

    // Shrinking BLINK_DIV below the current count restarts cleanly.
    wr(2'd2, 32'd10);
    repeat (7) @(posedge clk);
    wr(2'd2, 32'd2);
    chk("shrink_ph0", {31'd0, readdata[31]}, 32'd0);
    @(posedge clk); #1;
    chk("shrink_ph1", {31'd0, readdata[31]}, 32'd0);
    @(posedge clk); #1;
    chk("shrink_ph2", {31'd0, readdata[31]}, 32'd1);

    // BLINK_DIV write on a terminal-count edge: the clear wins.
    wr(2'd2, 32'd3);
    repeat (2) @(posedge clk);
    wr(2'd2, 32'd3);
    chk("tc_clear", {31'd0, readdata[31]}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("tc_ph5", {31'd0, readdata[31]}, 32'd0);
    @(posedge clk); #1;
    chk("tc_ph6", {31'd0, readdata[31]}, 32'd1);

    // BLINK_DIV=0 freezes the phase low and keeps the display lit.
    wr(2'd2, 32'd0);
    for (int n = 0; n < 100; n++) begin
      e.seg = 28'h000_0000;
      e.dpo = 4'h0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      sb_check("div0");
      chk("div0_ph", {31'd0, readdata[31]}, 32'd0);
    end

    // Reset while blinking in the off phase.
    wr(2'd2, 32'd3);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (readdata[31] && !seen) begin
        seen = 1'b1;
        break;
      end
    end
    chk("pre_rst_phase", {31'd0, seen}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_seg", {4'd0, seg_out}, 32'h0FFF_FFFF);
    chk("mid_rst_dp", {28'd0, dp_out}, 32'h0000_000F);
    rd_chk("mid_rst_div", 2'd2, 32'd25000000);
    rd_chk("mid_rst_ctrl", 2'd0, 32'd0);
    rd_chk("mid_rst_hex", 2'd1, 32'd0);
    rd_chk("mid_rst_dpreg", 2'd3, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_ph", {31'd0, readdata[31]}, 32'd0);
    chk("post_rst_seg", {4'd0, seg_out}, 32'h0FFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
